// File: rtl/bram.sv
// Single-port weight/bias RAM; optional constant preload image when BRAM_INIT_EN is defined.
// Latency: 2 enabled edges from address to dout; read-first on same-address read+write.
// Backpressure: none; en=0 freezes memory, read stage and dout.
module bram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int DEPTH      = 2**ADDR_WIDTH
`ifdef BRAM_INIT_EN
    , parameter INIT_FILE    = "weights.mem"
    , parameter int INIT_LEN = 1
    , parameter logic [INIT_LEN*DATA_WIDTH-1:0] INIT_IMAGE = 8'h7F
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    // Words not covered by a preload image stay zero.
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++)
            m[i] = '0;
`ifdef BRAM_INIT_EN
        for (int i = 0; i < INIT_LEN && i < DEPTH; i++)
            m[i] = INIT_IMAGE[i*DATA_WIDTH +: DATA_WIDTH];
`endif
        return m;
    endfunction

    mem_t                  mem      = init_mem();
    logic [DATA_WIDTH-1:0] rd_stage = '0;
    logic [DATA_WIDTH-1:0] dout_q   = '0;
    logic                  in_range;

    if (DEPTH >= 2**ADDR_WIDTH) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_part
        assign in_range = (32'(addr) < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst && en && wen && in_range)
            mem[addr] <= din;
    end

    // Read samples the pre-write contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_stage <= '0;
            dout_q   <= '0;
        end else if (en) begin
            if (ren)
                rd_stage <= in_range ? mem[addr] : '0;
            dout_q <= rd_stage;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_bram.sv
// Directed bench for bram: reference memory plus expected-data queue checked at output time.
module tb_bram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [17:0] addr = '0;
  logic [7:0]  din  = '0;
  logic [7:0]  dout;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [int];
  logic [7:0] exp_q [$];
  logic       rd_flag  = 1'b0;
  logic       out_flag = 1'b0;
  logic [7:0] last_exp = '0;

  bram dut (
    .clk(clk), .rst(rst), .en(en), .ren(ren), .wen(wen),
    .addr(addr), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
`ifdef BRAM_INIT_EN
    if (a == 0) return 8'h7F;
`endif
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update reference, advance, then compare any word now on dout.
  task automatic cyc(input logic r, input logic e, input logic rd, input logic wr,
                     input logic [17:0] a, input logic [7:0] d, input string tag);
    logic [7:0] e_val;
    rst = r; en = e; ren = rd; wen = wr; addr = a; din = d;
    if (!r && e && rd) exp_q.push_back(ref_rd(int'(a)));
    if (!r && e && wr) ref_mem[int'(a)] = d;
    @(posedge clk);
    #1;
    if (r) begin
      rd_flag = 1'b0; out_flag = 1'b0; exp_q.delete();
    end else if (e) begin
      out_flag = rd_flag; rd_flag = rd;
    end else begin
      out_flag = 1'b0;
    end
    if (out_flag) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s observed=%h expected=<queue empty>", tag, dout);
      end else begin
        e_val = exp_q.pop_front();
        last_exp = e_val;
        check(tag, dout, e_val);
      end
    end
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 8'd0, tag);
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 8'd0, "rst");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 8'd0, "rst");
    check("reset_dout", dout, 8'h00);

    // Initial contents of word 0
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'd0, 8'd0, "init_rd0");
    idle("init_rd0");

    // Write issued under reset must not land
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 18'd10, 8'h5A, "wr10");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'd10, 8'd0, "rd10_pre");
    idle("rd10_pre");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 18'd10, 8'hFF, "rst_wr");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 18'd0, 8'd0, "rst_wr");
    check("reset_after_activity", dout, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'd10, 8'd0, "rst_wr_blocked");
    idle("rst_wr_blocked");

    // Write then back-to-back read
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 18'd147504, 8'hA5, "wr");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 18'd147505, 8'h3C, "wr");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'd147504, 8'd0, "b2b_a5");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'd147505, 8'd0, "b2b_a5");
    idle("b2b_3c");
    idle("b2b_tail");

    // Burst of 8 with drain after ren falls
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 18'(147504 + i), 8'(i + 1), "preload");
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'(147504 + i), 8'd0, "burst");
    idle("burst_drain");
    check("burst_last", dout, 8'h08);
    idle("burst_tail");

    // Read-first on same-address read+write
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 18'd100, 8'h11, "wr100");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 18'd100, 8'h22, "read_first_old");
    idle("read_first_old");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'd100, 8'd0, "reread_new");
    idle("reread_new");
    idle("rf_tail");

    // en freeze in the middle of a burst
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 18'(2000 + i), 8'($urandom_range(1, 255)), "fz_preload");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'(2000 + i), 8'd0, "fz_burst");
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 18'(3000 + k), 8'hEE, "fz_hold");
      check("freeze_dout", dout, last_exp);
    end
    for (int i = 4; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'(2000 + i), 8'd0, "fz_resume");
    idle("fz_drain");
    idle("fz_tail");
    // Writes attempted while frozen must not have landed
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 18'd3000, 8'd0, "fz_nowrite");
    idle("fz_nowrite");
    idle("fz_nowrite_tail");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
